// File: rtl/alu_pkg.sv
// Shared ALU encodings, MIPS opcode/funct codes and decode selector types.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

  // 4-bit alu_control encoding consumed by the execute-stage ALU
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_MULT = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_DIV  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  // Which instruction field names the destination register
  typedef enum logic [1:0] {
    WR_NONE = 2'd0,
    WR_RD   = 2'd1,
    WR_RT   = 2'd2
  } wr_sel_e;

endpackage

// File: rtl/alu_op_decoder.sv
// Purely combinational MIPS opcode/funct -> ALU control, flags and operand selects.
// Latency: 0 cycles.
// Backpressure: none; output follows input.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       reg_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       branch_o,
  output logic       illegal_o,
  output logic       imm_zext_o,   // 1: zero-extend immediate, 0: sign-extend
  output logic       a_sel_rt_o,   // 1: operand a from rt (shifts), 0: from rs
  output logic       b_sel_imm_o,  // 1: operand b is the immediate, 0: from rt
  output logic       rt_used_o,    // rt is a true source (load-use check)
  output logic [1:0] wr_sel_o
);

  wr_sel_e wr_sel;

  assign wr_sel_o = wr_sel;

  // Decode table; anything not matched falls to illegal with every flag clear
  always_comb begin
    alu_ctrl_o  = ALU_AND;
    reg_write_o = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    branch_o    = 1'b0;
    illegal_o   = 1'b0;
    imm_zext_o  = 1'b0;
    a_sel_rt_o  = 1'b0;
    b_sel_imm_o = 1'b1;
    rt_used_o   = 1'b0;
    wr_sel      = WR_NONE;
    case (op_i)
      OP_RTYPE: begin
        // rt is read by every R-type encoding, legal or not
        rt_used_o   = 1'b1;
        reg_write_o = 1'b1;
        wr_sel      = WR_RD;
        b_sel_imm_o = 1'b0;
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_XOR:  alu_ctrl_o = ALU_XOR;
          FN_NOR:  alu_ctrl_o = ALU_NOR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          FN_MULT: alu_ctrl_o = ALU_MULT;
          FN_DIV:  alu_ctrl_o = ALU_DIV;
          // Shifts take the value from rt and the shamt through imm[10:6]
          FN_SLL: begin alu_ctrl_o = ALU_SLL; a_sel_rt_o = 1'b1; b_sel_imm_o = 1'b1; end
          FN_SRL: begin alu_ctrl_o = ALU_SRL; a_sel_rt_o = 1'b1; b_sel_imm_o = 1'b1; end
          FN_SRA: begin alu_ctrl_o = ALU_SRA; a_sel_rt_o = 1'b1; b_sel_imm_o = 1'b1; end
          default: begin
            illegal_o   = 1'b1;
            reg_write_o = 1'b0;
            wr_sel      = WR_NONE;
          end
        endcase
      end
      OP_ADDI: begin alu_ctrl_o = ALU_ADD; reg_write_o = 1'b1; wr_sel = WR_RT; end
      OP_SLTI: begin alu_ctrl_o = ALU_SLT; reg_write_o = 1'b1; wr_sel = WR_RT; end
      OP_ANDI: begin
        alu_ctrl_o = ALU_AND; reg_write_o = 1'b1; wr_sel = WR_RT; imm_zext_o = 1'b1;
      end
      OP_ORI: begin
        alu_ctrl_o = ALU_OR; reg_write_o = 1'b1; wr_sel = WR_RT; imm_zext_o = 1'b1;
      end
      OP_XORI: begin
        alu_ctrl_o = ALU_XOR; reg_write_o = 1'b1; wr_sel = WR_RT; imm_zext_o = 1'b1;
      end
      OP_LW: begin
        alu_ctrl_o = ALU_ADD; reg_write_o = 1'b1; mem_read_o = 1'b1; wr_sel = WR_RT;
      end
      // Stores and branches read rt but write nothing
      OP_SW: begin alu_ctrl_o = ALU_ADD; mem_write_o = 1'b1; rt_used_o = 1'b1; end
      OP_BEQ: begin alu_ctrl_o = ALU_SUB; branch_o = 1'b1; rt_used_o = 1'b1; end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue: decode, forward EX/MEM results, detect load-use, register into ID/EX.
// Latency: 1 cycle from ID inputs to ex_* outputs.
// Backpressure: stall freezes ID/EX; hazard_stall asks upstream to hold IF/ID and inserts a bubble.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int FWD_EN = 1,
  parameter int XLEN   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic            mem_wr_en,
  input  logic [4:0]      mem_wr_reg,
  input  logic [XLEN-1:0] mem_wr_data,
  output logic            hazard_stall,
  output logic            ex_valid,
  output logic [3:0]      ex_alu_control,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [XLEN-1:0] ex_rt_data,
  output logic [4:0]      ex_wr_reg,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_illegal
);

  logic [4:0] rs, rt, rd;
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];

  logic [3:0] dec_ctrl;
  logic       dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_illegal;
  logic       dec_imm_zext, dec_a_sel_rt, dec_b_sel_imm, dec_rt_used;
  logic [1:0] dec_wr_sel;

  alu_op_decoder u_dec (
    .op_i        (instr[31:26]),
    .funct_i     (instr[5:0]),
    .alu_ctrl_o  (dec_ctrl),
    .reg_write_o (dec_reg_write),
    .mem_read_o  (dec_mem_read),
    .mem_write_o (dec_mem_write),
    .branch_o    (dec_branch),
    .illegal_o   (dec_illegal),
    .imm_zext_o  (dec_imm_zext),
    .a_sel_rt_o  (dec_a_sel_rt),
    .b_sel_imm_o (dec_b_sel_imm),
    .rt_used_o   (dec_rt_used),
    .wr_sel_o    (dec_wr_sel)
  );

  // ID/EX pipeline register state
  logic            ex_valid_q, ex_valid_d;
  logic [3:0]      ex_ctrl_q, ex_ctrl_d;
  logic [XLEN-1:0] ex_a_q, ex_a_d;
  logic [XLEN-1:0] ex_b_q, ex_b_d;
  logic [XLEN-1:0] ex_rt_q, ex_rt_d;
  logic [4:0]      ex_wr_q, ex_wr_d;
  logic            ex_rw_q, ex_rw_d;
  logic            ex_mr_q, ex_mr_d;
  logic            ex_mw_q, ex_mw_d;
  logic            ex_br_q, ex_br_d;
  logic            ex_ill_q, ex_ill_d;

  // An EX-stage load has no result yet, so it is never a forwarding source
  logic ex_fwd_ok;
  assign ex_fwd_ok = (FWD_EN != 0) && ex_valid_q && ex_rw_q && !ex_mr_q;

  logic [XLEN-1:0] fwd_rs, fwd_rt;

  // Operand forwarding: r0 is hardwired zero, EX result beats MEM writeback
  always_comb begin
    fwd_rs = rs_data;
    fwd_rt = rt_data;
    if (rs == 5'd0)                                      fwd_rs = '0;
    else if (ex_fwd_ok && ex_wr_q == rs)                 fwd_rs = ex_alu_result;
    else if (FWD_EN != 0 && mem_wr_en && mem_wr_reg == rs) fwd_rs = mem_wr_data;
    if (rt == 5'd0)                                      fwd_rt = '0;
    else if (ex_fwd_ok && ex_wr_q == rt)                 fwd_rt = ex_alu_result;
    else if (FWD_EN != 0 && mem_wr_en && mem_wr_reg == rt) fwd_rt = mem_wr_data;
  end

  logic [XLEN-1:0] imm;
  assign imm = dec_imm_zext ? {{(XLEN-16){1'b0}}, instr[15:0]}
                            : {{(XLEN-16){instr[15]}}, instr[15:0]};

  logic [4:0] wr_reg;

  // Destination register selection
  always_comb begin
    case (dec_wr_sel)
      WR_RD:   wr_reg = rd;
      WR_RT:   wr_reg = rt;
      default: wr_reg = 5'd0;
    endcase
  end

  // Load-use: the EX load's destination is a source this instruction really reads
  assign hazard_stall = in_valid && ex_valid_q && ex_mr_q && (ex_wr_q != 5'd0) &&
                        ((ex_wr_q == rs) || (dec_rt_used && ex_wr_q == rt));

  // ID/EX next state: stall holds, flush/hazard/no-input bubble, else capture
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_rt_d    = ex_rt_q;
    ex_wr_d    = ex_wr_q;
    ex_rw_d    = ex_rw_q;
    ex_mr_d    = ex_mr_q;
    ex_mw_d    = ex_mw_q;
    ex_br_d    = ex_br_q;
    ex_ill_d   = ex_ill_q;
    if (!stall) begin
      if (flush || hazard_stall || !in_valid) begin
        ex_valid_d = 1'b0;
        ex_rw_d    = 1'b0;
        ex_mr_d    = 1'b0;
        ex_mw_d    = 1'b0;
        ex_br_d    = 1'b0;
        ex_ill_d   = 1'b0;
      end else begin
        ex_valid_d = 1'b1;
        ex_ctrl_d  = dec_ctrl;
        ex_a_d     = dec_a_sel_rt ? fwd_rt : fwd_rs;
        ex_b_d     = dec_b_sel_imm ? imm : fwd_rt;
        ex_rt_d    = fwd_rt;
        ex_wr_d    = wr_reg;
        ex_rw_d    = dec_reg_write;
        ex_mr_d    = dec_mem_read;
        ex_mw_d    = dec_mem_write;
        ex_br_d    = dec_branch;
        ex_ill_d   = dec_illegal;
      end
    end
  end

  // ID/EX register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_rt_q    <= '0;
      ex_wr_q    <= '0;
      ex_rw_q    <= 1'b0;
      ex_mr_q    <= 1'b0;
      ex_mw_q    <= 1'b0;
      ex_br_q    <= 1'b0;
      ex_ill_q   <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_rt_q    <= ex_rt_d;
      ex_wr_q    <= ex_wr_d;
      ex_rw_q    <= ex_rw_d;
      ex_mr_q    <= ex_mr_d;
      ex_mw_q    <= ex_mw_d;
      ex_br_q    <= ex_br_d;
      ex_ill_q   <= ex_ill_d;
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_alu_control = ex_ctrl_q;
  assign ex_a           = ex_a_q;
  assign ex_b           = ex_b_q;
  assign ex_rt_data     = ex_rt_q;
  assign ex_wr_reg      = ex_wr_q;
  assign ex_reg_write   = ex_rw_q;
  assign ex_mem_read    = ex_mr_q;
  assign ex_mem_write   = ex_mw_q;
  assign ex_branch      = ex_br_q;
  assign ex_illegal     = ex_ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized traffic.
// Latency: model expects ex_* one clock after inputs are presented.
// Backpressure: bench drives stall/flush and follows hazard_stall through its model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] rs_data, rt_data;
  logic        stall, flush;
  logic [31:0] ex_alu_result;
  logic        mem_wr_en;
  logic [4:0]  mem_wr_reg;
  logic [31:0] mem_wr_data;
  logic        hazard_stall, ex_valid;
  logic [3:0]  ex_alu_control;
  logic [31:0] ex_a, ex_b, ex_rt_data;
  logic [4:0]  ex_wr_reg;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .flush(flush),
    .ex_alu_result(ex_alu_result), .mem_wr_en(mem_wr_en), .mem_wr_reg(mem_wr_reg),
    .mem_wr_data(mem_wr_data), .hazard_stall(hazard_stall), .ex_valid(ex_valid),
    .ex_alu_control(ex_alu_control), .ex_a(ex_a), .ex_b(ex_b), .ex_rt_data(ex_rt_data),
    .ex_wr_reg(ex_wr_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  // Instruction tables straight from the encoding description
  logic [5:0] r_fn   [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2A, 6'h00, 6'h02, 6'h03, 6'h18, 6'h1A};
  logic [3:0] r_code [12] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0100, 4'b1100,
                              4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b0101, 4'b1011};
  logic [5:0] i_op   [8]  = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h23, 6'h2B, 6'h04};
  logic [3:0] i_code [8]  = '{4'b0010, 4'b0000, 4'b0001, 4'b0100, 4'b0111,
                              4'b0010, 4'b0010, 4'b0110};

  // Expected contents of the execute stage
  typedef struct {
    logic       valid, ill, rw, mr, mw, br;
    logic [3:0] ctrl;
    logic [31:0] a, b, rtd;
    logic [4:0] wr;
    logic       known;  // data fields are defined (after reset or a legal capture)
  } ex_t;

  ex_t m;
  int  n_err = 0;
  int  n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Value a source register really holds, seen from the ID stage
  function automatic logic [31:0] fwd_m(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return 32'd0;
    if (m.valid && m.rw && !m.mr && m.wr == r) return ex_alu_result;
    if (mem_wr_en && mem_wr_reg == r) return mem_wr_data;
    return rf;
  endfunction

  function automatic logic model_haz();
    logic [5:0] op;
    logic       rt_used;
    op = instr[31:26];
    rt_used = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    return in_valid && m.valid && m.mr && (m.wr != 5'd0) &&
           ((m.wr == instr[25:21]) || (rt_used && m.wr == instr[20:16]));
  endfunction

  function automatic ex_t model_next(input logic haz);
    ex_t n;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic legal, shift, zext, is_sw, is_beq, is_lw;
    logic [3:0] code;
    logic [31:0] imm;
    n = m;
    if (!rst_n) begin
      n = '{default: '0};
      n.known = 1'b1;
      return n;
    end
    if (stall) return n;
    if (flush || haz || !in_valid) begin
      n.valid = 0; n.ill = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.br = 0; n.known = 0;
      return n;
    end
    op = instr[31:26]; fn = instr[5:0];
    rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11];
    legal = 0; code = 4'd0;
    if (op == 6'h00) begin
      for (int i = 0; i < 12; i++) if (r_fn[i] == fn) begin legal = 1; code = r_code[i]; end
    end else begin
      for (int i = 0; i < 8; i++) if (i_op[i] == op) begin legal = 1; code = i_code[i]; end
    end
    n.valid = 1;
    if (!legal) begin
      n.ill = 1; n.rw = 0; n.mr = 0; n.mw = 0; n.br = 0; n.wr = 5'd0; n.known = 0;
      return n;
    end
    shift  = (op == 6'h00) && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03);
    zext   = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
    is_lw  = (op == 6'h23);
    is_sw  = (op == 6'h2B);
    is_beq = (op == 6'h04);
    imm    = zext ? {16'd0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    n.ill  = 0;
    n.ctrl = code;
    n.a    = shift ? fwd_m(rt, rt_data) : fwd_m(rs, rs_data);
    n.b    = (op == 6'h00 && !shift) ? fwd_m(rt, rt_data) : imm;
    n.rtd  = fwd_m(rt, rt_data);
    n.wr   = (op == 6'h00) ? rd : ((is_sw || is_beq) ? 5'd0 : rt);
    n.rw   = !(is_sw || is_beq);
    n.mr   = is_lw;
    n.mw   = is_sw;
    n.br   = is_beq;
    n.known = 1;
    return n;
  endfunction

  task automatic compare_outputs();
    chk("ex_valid", ex_valid, m.valid);
    chk("ex_illegal", ex_illegal, m.ill);
    chk("ex_reg_write", ex_reg_write, m.rw);
    chk("ex_mem_read", ex_mem_read, m.mr);
    chk("ex_mem_write", ex_mem_write, m.mw);
    chk("ex_branch", ex_branch, m.br);
    if (m.known) begin
      chk("ex_alu_control", ex_alu_control, m.ctrl);
      chk("ex_a", ex_a, m.a);
      chk("ex_b", ex_b, m.b);
      chk("ex_rt_data", ex_rt_data, m.rtd);
      chk("ex_wr_reg", ex_wr_reg, m.wr);
    end
  endtask

  // One clock: check hazard_stall on the presented inputs, advance model, check ex_*
  task automatic step(input bit chk_haz);
    logic h;
    ex_t nx;
    #1;
    h = model_haz();
    if (chk_haz) chk("hazard_stall", hazard_stall, h);
    nx = model_next(h);
    @(posedge clk);
    m = nx;
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle_side();
    stall = 0; flush = 0; mem_wr_en = 0; mem_wr_reg = 0; mem_wr_data = 0;
    ex_alu_result = 32'hDEAD_0000;
  endtask

  initial begin
    m = '{default: '0};
    rst_n = 0; in_valid = 1; instr = enc_r(5'd2, 5'd3, 5'd1, 5'd0, 6'h20);
    rs_data = 32'h1234; rt_data = 32'h5678;
    idle_side();
    @(negedge clk);

    // Reset held for two cycles with a valid instruction present
    step(1'b0);
    step(1'b1);
    chk("reset_valid", ex_valid, 1'b0);
    chk("reset_a", ex_a, 32'd0);
    chk("reset_reg_write", ex_reg_write, 1'b0);

    // First capture right after reset release
    rst_n = 1;
    step(1'b1);
    chk("first_capture_valid", ex_valid, 1'b1);
    chk("first_capture_wr", ex_wr_reg, 32'd1);

    // Decode sweep with rs=5, rt=3, a nop in between so nothing interferes
    rs_data = 32'h55; rt_data = 32'h33;
    for (int i = 0; i < 12; i++) begin
      instr = enc_r(5'd5, 5'd3, 5'd7, 5'd2, r_fn[i]);
      step(1'b1);
      chk("sweep_r_code", ex_alu_control, r_code[i]);
      instr = 32'd0;
      step(1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      instr = enc_i(i_op[i], 5'd5, 5'd3, 16'h8004);
      step(1'b1);
      chk("sweep_i_code", ex_alu_control, i_code[i]);
      instr = 32'd0;
      step(1'b1);
    end

    // sll $2,$3,4
    rt_data = 32'd3;
    instr = enc_r(5'd0, 5'd3, 5'd2, 5'd4, 6'h00);
    step(1'b1);
    chk("sll_a", ex_a, 32'd3);
    chk("sll_shamt", ex_b[10:6], 32'd4);
    chk("sll_code", ex_alu_control, 4'b1000);
    chk("sll_wr", ex_wr_reg, 32'd2);

    // Forwarding priority on r5
    instr = enc_i(6'h08, 5'd0, 5'd5, 16'd1);
    step(1'b1);
    ex_alu_result = 32'h11; mem_wr_en = 1; mem_wr_reg = 5'd5; mem_wr_data = 32'h22;
    rs_data = 32'h99;
    instr = enc_r(5'd5, 5'd0, 5'd1, 5'd0, 6'h20);
    step(1'b1);
    chk("fwd_ex_wins", ex_a, 32'h11);
    step(1'b1);
    chk("fwd_mem", ex_a, 32'h22);
    mem_wr_reg = 5'd0;
    instr = enc_r(5'd0, 5'd0, 5'd1, 5'd0, 6'h20);
    step(1'b1);
    chk("fwd_r0", ex_a, 32'd0);
    idle_side();

    // Load-use: lw $4 then add $1,$4,$2
    instr = enc_i(6'h23, 5'd0, 5'd4, 16'd8);
    step(1'b1);
    instr = enc_r(5'd4, 5'd2, 5'd1, 5'd0, 6'h20);
    #1;
    chk("loaduse_hazard", hazard_stall, 1'b1);
    step(1'b1);
    chk("loaduse_bubble", ex_valid, 1'b0);
    step(1'b1);
    chk("loaduse_capture", ex_valid, 1'b1);
    chk("loaduse_wr", ex_wr_reg, 32'd1);

    // Stall beats flush; then flush alone
    instr = enc_r(5'd6, 5'd7, 5'd9, 5'd0, 6'h22);
    stall = 1; flush = 1;
    step(1'b1);
    chk("stall_hold_valid", ex_valid, 1'b1);
    chk("stall_hold_code", ex_alu_control, 4'b0010);
    chk("stall_hold_wr", ex_wr_reg, 32'd1);
    stall = 0;
    step(1'b1);
    chk("flush_bubble", ex_valid, 1'b0);
    flush = 0;

    // Illegal opcode
    instr = enc_i(6'h3F, 5'd1, 5'd2, 16'd0);
    step(1'b1);
    chk("illegal_flag", ex_illegal, 1'b1);
    chk("illegal_valid", ex_valid, 1'b1);
    chk("illegal_rw", ex_reg_write, 1'b0);
    chk("illegal_mw", ex_mem_write, 1'b0);

    // Randomized traffic on a small register window to provoke hits
    for (int c = 0; c < 800; c++) begin
      int k;
      k = $urandom_range(0, 21);
      if (k < 12)
        instr = enc_r(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom), r_fn[k]);
      else if (k < 20)
        instr = enc_i(i_op[k-12], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      16'($urandom));
      else if (k == 20)
        instr = ($urandom_range(0, 1) == 0) ? enc_i(6'h3F, 5'd1, 5'd2, 16'($urandom))
                                            : enc_r(5'd3, 5'd4, 5'd5, 5'd0, 6'h3F);
      else
        instr = 32'd0;
      rst_n         = ($urandom_range(0, 49) != 0);
      in_valid      = ($urandom_range(0, 7) != 0);
      stall         = ($urandom_range(0, 9) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      rs_data       = $urandom;
      rt_data       = $urandom;
      ex_alu_result = $urandom;
      mem_wr_en     = $urandom_range(0, 1) == 1;
      mem_wr_reg    = 5'($urandom_range(0, 7));
      mem_wr_data   = $urandom;
      step(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
